// File: rtl/ym_phase_seq_pkg.sv
// ym_phase_seq_pkg: shared definitions for the two-phase sequencer.
// Contents: RUN/HELD state encoding, per-chip default HALF/SLOTS/SLOT_W constants.
// No ports; imported by ym_phase_seq_if, ym_phase_cnt and ym_phase_seq.
package ym_phase_seq_pkg;

  // Sequencer state: free-running or stalled at a period boundary.
  typedef enum logic {
    RUN  = 1'b0,
    HELD = 1'b1
  } seq_state_t;

  // ym3438 build: 6 MCLK per half period, 24 slots per frame.
  localparam int YM3438_HALF   = 6;
  localparam int YM3438_SLOTS  = 24;
  localparam int YM3438_SLOT_W = 5;

  // ym7101 build defaults.
  localparam int YM7101_HALF   = 4;
  localparam int YM7101_SLOTS  = 16;
  localparam int YM7101_SLOT_W = 4;

  // Full c1/c2 period in MCLK cycles.
  function automatic int period_of(input int half);
    return 2 * half;
  endfunction

endpackage

// File: rtl/ym_phase_seq_if.sv
// ym_phase_seq_if: control and phase/slot bundle between the sequencer and its consumers.
// Latency: n/a (wires only). Backpressure: none; hold is the only stall path.
// Ports: hold, sync_in (consumer -> sequencer); c1, c2, slot, slot_last, period_stb, hold_ack (sequencer -> consumer).
interface ym_phase_seq_if
  import ym_phase_seq_pkg::*;
#(
  parameter int SLOT_W = YM3438_SLOT_W
);
  logic              hold;
  logic              sync_in;
  logic              c1;
  logic              c2;
  logic [SLOT_W-1:0] slot;
  logic              slot_last;
  logic              period_stb;
  logic              hold_ack;

  // master: the sequencer itself.
  modport master (
    input  hold, sync_in,
    output c1, c2, slot, slot_last, period_stb, hold_ack
  );

  // slave: whoever requests hold/resync and consumes the phases.
  modport slave (
    output hold, sync_in,
    input  c1, c2, slot, slot_last, period_stb, hold_ack
  );
endinterface

// File: rtl/ym_phase_cnt.sv
// ym_phase_cnt: MCLK divider producing non-overlapping registered c1/c2 enables.
// Latency: c1/c2 lag ph_cnt by one MCLK edge. Backpressure: frozen (ph_cnt held, c1/c2 low) while state is HELD.
// Ports: MCLK, reset, state (in); c1, c2 (registered out); boundary (comb out, high on the last count of a period in RUN).
module ym_phase_cnt
  import ym_phase_seq_pkg::*;
#(
  parameter int HALF = YM3438_HALF
) (
  input  logic       MCLK,
  input  logic       reset,
  input  seq_state_t state,
  output logic       c1,
  output logic       c2,
  output logic       boundary
);

  localparam int P     = period_of(HALF);
  localparam int CNT_W = $clog2(P);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(P - 1);
  localparam logic [CNT_W-1:0] C1_END   = CNT_W'(HALF - 2);
  localparam logic [CNT_W-1:0] C2_BEG   = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] C2_END   = CNT_W'(P - 2);

  logic [CNT_W-1:0] ph_cnt;

  assign boundary = (state == RUN) && (ph_cnt == CNT_LAST);

  // Counts HALF-1 and P-1 drive neither phase: those are the dead gaps
  // that keep c1 and c2 from overlapping at either transition.
  always_ff @(posedge MCLK) begin
    if (reset) begin
      ph_cnt <= '0;
      c1     <= 1'b0;
      c2     <= 1'b0;
    end else if (state == RUN) begin
      ph_cnt <= boundary ? '0 : ph_cnt + 1'b1;
      c1     <= (ph_cnt <= C1_END);
      c2     <= (ph_cnt >= C2_BEG) && (ph_cnt <= C2_END);
    end else begin
      // HELD is only entered on a wrap, so ph_cnt is already 0 here.
      c1     <= 1'b0;
      c2     <= 1'b0;
    end
  end

endmodule

// File: rtl/ym_phase_seq.sv
// ym_phase_seq: master two-phase sequencer; c1/c2 phase enables plus frame slot tracking.
// Latency: all outputs registered (slot_last decoded from the slot register); slot advances on the wrap edge.
// Backpressure: hold stalls only at a period boundary so no phase is cut short; hold_ack while stalled.
// Ports: MCLK, reset (sync, active-high); bus (master modport: hold, sync_in in; c1, c2, slot, slot_last, period_stb, hold_ack out).
module ym_phase_seq
  import ym_phase_seq_pkg::*;
#(
  parameter int HALF   = YM3438_HALF,
  parameter int SLOTS  = YM3438_SLOTS,
  parameter int SLOT_W = YM3438_SLOT_W
) (
  input  logic           MCLK,
  input  logic           reset,
  ym_phase_seq_if.master bus
);

  localparam logic [SLOT_W-1:0] SLOT_MAX = SLOT_W'(SLOTS - 1);

  seq_state_t        state;
  logic [SLOT_W-1:0] slot;
  logic              sync_pend;
  logic              period_stb;
  logic              boundary;

  ym_phase_cnt #(
    .HALF (HALF)
  ) u_cnt (
    .MCLK     (MCLK),
    .reset    (reset),
    .state    (state),
    .c1       (bus.c1),
    .c2       (bus.c2),
    .boundary (boundary)
  );

  always_ff @(posedge MCLK) begin
    if (reset) begin
      state      <= RUN;
      slot       <= '0;
      sync_pend  <= 1'b0;
      period_stb <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          period_stb <= boundary;
          if (boundary) begin
            // A resync arriving on the wrap edge itself counts as pending.
            if (sync_pend || bus.sync_in) slot <= '0;
            else if (slot == SLOT_MAX)     slot <= '0;
            else                           slot <= slot + 1'b1;
            sync_pend <= 1'b0;
            // Boundary update above still lands before the stall.
            state     <= bus.hold ? HELD : RUN;
          end else if (bus.sync_in) begin
            sync_pend <= 1'b1;
          end
        end
        HELD: begin
          period_stb <= 1'b0;
          // No phase is running, so a resync can apply immediately.
          if (bus.sync_in) slot <= '0;
          if (!bus.hold)   state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  assign bus.slot       = slot;
  assign bus.slot_last  = (slot == SLOT_MAX);
  assign bus.period_stb = period_stb;
  assign bus.hold_ack   = (state == HELD);

endmodule

// File: tb/tb_ym_phase_seq.sv
// tb_ym_phase_seq: directed bench for ym_phase_seq (HALF=6, SLOTS=24, P=12).
// Expected output vectors are queued per MCLK edge; a negedge monitor pops and compares them.
// Vector layout: {c1, c2, slot[4:0], period_stb, hold_ack, slot_last}.
module tb_ym_phase_seq;
  import ym_phase_seq_pkg::*;

  localparam int HALF  = 6;
  localparam int SLOTS = 24;
  localparam int P     = 12;

  logic MCLK  = 1'b0;
  logic reset = 1'b1;

  ym_phase_seq_if #(.SLOT_W(5)) bus ();

  ym_phase_seq #(
    .HALF   (HALF),
    .SLOTS  (SLOTS),
    .SLOT_W (5)
  ) dut (
    .MCLK  (MCLK),
    .reset (reset),
    .bus   (bus)
  );

  always #5 MCLK = ~MCLK;

  typedef struct {
    int         cyc;
    logic [9:0] v;
    string      name;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_on   = 1'b0;
  int   base;

  function automatic void push(input int at, input logic c1, input logic c2,
                               input int s, input logic stb, input logic ack,
                               input string nm);
    exp_t x;
    logic [4:0] sl;
    sl     = 5'(s);
    x.cyc  = at;
    x.v    = {c1, c2, sl, stb, ack, (s == SLOTS - 1)};
    x.name = nm;
    q.push_back(x);
  endfunction

  // Free-running expectation kk edges after (re)start from ph_cnt=0:
  // the edge samples count (kk-1) mod P, and the slot has advanced kk/P times.
  function automatic void push_run(input int b, input int k, input int k0,
                                   input int s0, input string nm);
    int kk, ph, s;
    kk = k - k0;
    ph = (kk - 1) % P;
    s  = (s0 + kk / P) % SLOTS;
    push(b + k, ph <= HALF - 2, (ph >= HALF) && (ph <= P - 2), s, ph == P - 1, 1'b0, nm);
  endfunction

  task automatic step(input logic h, input logic s, input logic r);
    bus.hold    = h;
    bus.sync_in = s;
    reset       = r;
    @(posedge MCLK);
    #1;
    cyc++;
  endtask

  // Monitor: compares every queued vector due on this edge; flags overlap each cycle.
  initial begin
    forever begin
      @(negedge MCLK);
      if (mon_on) begin
        n_checks++;
        if (bus.c1 && bus.c2) begin
          n_fail++;
          $display("FAIL overlap cyc=%0d: c1=%b c2=%b, required not both 1", cyc, bus.c1, bus.c2);
        end
        while (q.size() > 0 && q[0].cyc <= cyc) begin
          e = q.pop_front();
          n_checks++;
          if (e.cyc < cyc) begin
            n_fail++;
            $display("FAIL %s missed: due cyc %0d, now %0d", e.name, e.cyc, cyc);
          end else if ({bus.c1, bus.c2, bus.slot, bus.period_stb, bus.hold_ack, bus.slot_last} !== e.v) begin
            n_fail++;
            $display("FAIL %s cyc=%0d: got c1c2=%b%b slot=%0d stb=%b ack=%b last=%b, required c1c2=%b%b slot=%0d stb=%b ack=%b last=%b",
                     e.name, cyc, bus.c1, bus.c2, bus.slot, bus.period_stb, bus.hold_ack, bus.slot_last,
                     e.v[9], e.v[8], e.v[7:3], e.v[2], e.v[1], e.v[0]);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.hold    = 1'b0;
    bus.sync_in = 1'b0;
    step(0, 0, 1);
    step(0, 0, 1);
    mon_on = 1'b1;

    // Run A: reset state, first-period timing, full frame wrap, then reset at a c2 edge.
    base = cyc + 1;
    push(base, 0, 0, 0, 0, 0, "reset_state");
    step(0, 0, 1);
    for (int k = 1; k <= 296; k++) push_run(base, k, 0, 0, "free_run");
    push(base + 297, 0, 0, 0, 0, 0, "reset_mid_c2");
    for (int k = 1; k <= 296; k++) step(0, 0, 0);
    step(0, 0, 1);

    // Run B: hold pulse inside c1 is ignored; hold across the wrap stalls until released.
    base = cyc;
    for (int k = 1; k <= 11; k++) push_run(base, k, 0, 0, "hold_ignored");
    push(base + 12, 0, 0, 1, 1, 1, "hold_enter");
    for (int k = 13; k <= 39; k++) push(base + k, 0, 0, 1, 0, 1, "held");
    push(base + 40, 0, 0, 1, 0, 0, "hold_release");
    for (int k = 41; k <= 64; k++) push_run(base, k, 40, 1, "after_hold");
    for (int k = 1; k <= 64; k++) step((k == 3) || (k >= 12 && k <= 39), 0, 0);
    push(cyc + 1, 0, 0, 0, 0, 0, "reset_after_hold");
    step(0, 0, 1);

    // Run C: resync mid-period is deferred to the wrap; slot goes 7 -> 0.
    base = cyc;
    for (int k = 1; k <= 95; k++)   push_run(base, k, 0, 0, "pre_sync");
    for (int k = 96; k <= 110; k++) push_run(base, k, 0, 16, "post_sync");
    for (int k = 1; k <= 110; k++) step(0, k == 90, 0);
    push(cyc + 1, 0, 0, 0, 0, 0, "reset_after_sync");
    step(0, 0, 1);

    // Run D: hold and resync on the same wrap edge, resync again while held.
    base = cyc;
    for (int k = 1; k <= 23; k++) push_run(base, k, 0, 0, "pre_hold_sync");
    push(base + 24, 0, 0, 0, 1, 1, "hold_sync_enter");
    for (int k = 25; k <= 29; k++) push(base + k, 0, 0, 0, 0, 1, "held_sync");
    push(base + 30, 0, 0, 0, 0, 0, "hold_sync_release");
    for (int k = 31; k <= 56; k++) push_run(base, k, 30, 0, "after_hold_sync");
    for (int k = 1; k <= 56; k++) step((k >= 24) && (k <= 29), (k == 24) || (k == 27), 0);

    step(0, 0, 0);
    @(negedge MCLK);
    #1;
    mon_on = 1'b0;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: %0d expectations left, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
